// File: rtl/launcher_pkg.sv
// Shared types and default sizing for the processor run launcher.
package launcher_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        STRT,
        RUN,
        FIN
    } state_e;

    localparam int unsigned DEF_CW           = 16;
    localparam int unsigned DEF_RST_CYCLES   = 2;
    localparam int unsigned DEF_START_CYCLES = 2;
    localparam int unsigned DEF_TIMEOUT      = 1000;
    localparam int unsigned DEF_PW           = 2;

endpackage

// File: rtl/prog_launcher_phase_counter.sv
// Phase counter shared by the launcher's RST, STRT and RUN phases.
// term_o flags the last cycle of a phase (count == limit-1).
module phase_counter #(
    parameter int unsigned CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [CW-1:0] limit_i,
    output logic [CW-1:0] count_o,
    output logic          term_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins over enable.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign term_o  = (count_q == (limit_i - CW'(1)));

endmodule

// File: rtl/prog_launcher.sv
// Host-side run controller: drives the processor's DutReset/Start and waits
// for Ack, measuring run length and abandoning runaway programs on timeout.
module prog_launcher
    import launcher_pkg::*;
#(
    parameter int unsigned CW           = DEF_CW,
    parameter int unsigned RST_CYCLES   = DEF_RST_CYCLES,
    parameter int unsigned START_CYCLES = DEF_START_CYCLES,
    parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
    parameter int unsigned PW           = DEF_PW
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          RunReq,
    input  logic [PW-1:0] RunProg,
    input  logic          ResetFirst,
    input  logic          Ack,
    output logic          DutReset,
    output logic          Start,
    output logic [PW-1:0] ProgSel,
    output logic          Busy,
    output logic          Done,
    output logic          TimedOut,
    output logic [CW-1:0] CycleCount
);

    state_e        state_q, state_d;
    logic [PW-1:0] prog_q, prog_d;
    logic          timed_q, timed_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic          dutrst_q, dutrst_d;
    logic          start_q, start_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          cnt_clr;
    logic          cnt_en;
    logic          cnt_term;
    logic [CW-1:0] cnt_count;
    logic [CW-1:0] cnt_limit;

    // Phase length for the shared counter, selected by the current state.
    always_comb begin
        cnt_limit = CW'(TIMEOUT);
        case (state_q)
            RST:     cnt_limit = CW'(RST_CYCLES);
            STRT:    cnt_limit = CW'(START_CYCLES);
            default: cnt_limit = CW'(TIMEOUT);
        endcase
    end

    phase_counter #(
        .CW(CW)
    ) u_phase (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .limit_i (cnt_limit),
        .count_o (cnt_count),
        .term_o  (cnt_term)
    );

    // Next-state, latched run data and counter control.
    always_comb begin
        state_d = state_q;
        prog_d  = prog_q;
        timed_d = timed_q;
        cyc_d   = cyc_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (RunReq) begin
                    prog_d  = RunProg;
                    timed_d = 1'b0;
                    cnt_clr = 1'b1;
                    state_d = ResetFirst ? RST : STRT;
                end
            end
            RST: begin
                if (cnt_term) begin
                    cnt_clr = 1'b1;
                    state_d = STRT;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            STRT: begin
                // Ack is deliberately ignored: it may still be the previous
                // program's completion flag.
                if (cnt_term) begin
                    cnt_clr = 1'b1;
                    state_d = RUN;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            RUN: begin
                // Ack takes priority over a coincident timeout.
                if (Ack) begin
                    cyc_d   = cnt_count;
                    state_d = FIN;
                end else if (cnt_term) begin
                    cyc_d   = CW'(TIMEOUT);
                    timed_d = 1'b1;
                    state_d = FIN;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // aligned with the state they belong to.
    always_comb begin
        dutrst_d = (state_d == RST);
        start_d  = (state_d == STRT);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == FIN);
    end

    // State and output registers; the processor is held in reset while the
    // launcher itself is in reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            prog_q   <= '0;
            timed_q  <= 1'b0;
            cyc_q    <= '0;
            dutrst_q <= 1'b1;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prog_q   <= prog_d;
            timed_q  <= timed_d;
            cyc_q    <= cyc_d;
            dutrst_q <= dutrst_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign DutReset   = dutrst_q;
    assign Start      = start_q;
    assign ProgSel    = prog_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign TimedOut   = timed_q;
    assign CycleCount = cyc_q;

endmodule

// File: tb/tb_prog_launcher.sv
// Bench for prog_launcher: two instances (long and short timeout) share the
// stimulus; a cycle-level expectation is derived from the run rules.
module tb_prog_launcher;

    localparam int RC    = 2;
    localparam int SC    = 2;
    localparam int TOUT0 = 1000;
    localparam int TOUT1 = 20;
    localparam int NEVER = 1 << 20;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       RunReq = 1'b0;
    logic [1:0] RunProg = '0;
    logic       ResetFirst = 1'b0;
    logic       Ack = 1'b0;

    logic        dr[2];
    logic        st[2];
    logic [1:0]  ps[2];
    logic        bz[2];
    logic        dn[2];
    logic        to[2];
    logic [15:0] cc[2];

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int prev_cc[2] = '{0, 0};
    bit prev_to[2] = '{0, 0};

    always #5 Clk = ~Clk;

    prog_launcher #(
        .CW(16), .RST_CYCLES(RC), .START_CYCLES(SC), .TIMEOUT(TOUT0), .PW(2)
    ) u_long (
        .Clk(Clk), .Reset(Reset), .RunReq(RunReq), .RunProg(RunProg),
        .ResetFirst(ResetFirst), .Ack(Ack), .DutReset(dr[0]), .Start(st[0]),
        .ProgSel(ps[0]), .Busy(bz[0]), .Done(dn[0]), .TimedOut(to[0]),
        .CycleCount(cc[0])
    );

    prog_launcher #(
        .CW(16), .RST_CYCLES(RC), .START_CYCLES(SC), .TIMEOUT(TOUT1), .PW(2)
    ) u_short (
        .Clk(Clk), .Reset(Reset), .RunReq(RunReq), .RunProg(RunProg),
        .ResetFirst(ResetFirst), .Ack(Ack), .DutReset(dr[1]), .Start(st[1]),
        .ProgSel(ps[1]), .Busy(bz[1]), .Done(dn[1]), .TimedOut(to[1]),
        .CycleCount(cc[1])
    );

    function automatic int tout(input int d);
        return (d == 0) ? TOUT0 : TOUT1;
    endfunction

    // One run from request to idle. k = RUN cycle index where Ack is first
    // sampled high (NEVER for none); ack_pre = Ack level before RUN.
    task automatic do_run(input bit rf, input logic [1:0] prog, input int k,
                          input bit ack_pre, input bit noise);
        int base, first, last;
        int de[2];
        int cce[2];
        bit toe[2];
        base = (rf ? RC : 0) + SC;
        for (int d = 0; d < 2; d++) begin
            toe[d] = !(k < tout(d));
            cce[d] = toe[d] ? tout(d) : k;
            de[d]  = base + (toe[d] ? tout(d) - 1 : k) + 1;
        end
        first = (de[0] < de[1]) ? de[0] : de[1];
        last  = (de[0] > de[1]) ? de[0] : de[1];
        @(negedge Clk);
        RunReq = 1'b1; RunProg = prog; ResetFirst = rf; Ack = ack_pre;
        for (int e = 0; e <= last + 2; e++) begin
            @(negedge Clk);
            for (int d = 0; d < 2; d++) begin
                bit exp_dr, exp_st, exp_bz, exp_dn, exp_to;
                int exp_cc;
                exp_dr = rf && (e < RC);
                exp_st = (e >= base - SC) && (e < base);
                exp_bz = (e <= de[d]);
                exp_dn = (e == de[d]);
                exp_to = (e >= de[d]) ? toe[d] : 1'b0;
                exp_cc = (e >= de[d]) ? cce[d] : prev_cc[d];
                chk_cnt++;
                if (dr[d] !== exp_dr) $display("FAIL dutreset d=%0d e=%0d got %b exp %b", d, e, dr[d], exp_dr);
                else pass_cnt++;
                chk_cnt++;
                if (st[d] !== exp_st) $display("FAIL start d=%0d e=%0d got %b exp %b", d, e, st[d], exp_st);
                else pass_cnt++;
                chk_cnt++;
                if (bz[d] !== exp_bz) $display("FAIL busy d=%0d e=%0d got %b exp %b", d, e, bz[d], exp_bz);
                else pass_cnt++;
                chk_cnt++;
                if (dn[d] !== exp_dn) $display("FAIL done d=%0d e=%0d got %b exp %b", d, e, dn[d], exp_dn);
                else pass_cnt++;
                chk_cnt++;
                if (to[d] !== exp_to) $display("FAIL timedout d=%0d e=%0d got %b exp %b", d, e, to[d], exp_to);
                else pass_cnt++;
                chk_cnt++;
                if (cc[d] !== 16'(exp_cc)) $display("FAIL cyclecount d=%0d e=%0d got %0d exp %0d", d, e, cc[d], exp_cc);
                else pass_cnt++;
                chk_cnt++;
                if (ps[d] !== prog) $display("FAIL progsel d=%0d e=%0d got %0d exp %0d", d, e, ps[d], prog);
                else pass_cnt++;
            end
            // Noise requests while busy, including one in the first FIN cycle.
            if (noise && e <= first) RunReq = (e == first) ? 1'b1 : 1'($urandom % 2);
            else RunReq = 1'b0;
            RunProg    = 2'($urandom);
            ResetFirst = 1'($urandom);
            Ack = (e < base) ? ack_pre : ((e - base) >= k);
        end
        Ack = 1'b0; RunReq = 1'b0;
        for (int d = 0; d < 2; d++) begin
            prev_cc[d] = cce[d];
            prev_to[d] = toe[d];
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        for (int d = 0; d < 2; d++) begin
            chk_cnt++;
            if (dr[d] !== 1'b1 || st[d] !== 1'b0 || bz[d] !== 1'b0 || dn[d] !== 1'b0 ||
                to[d] !== 1'b0 || cc[d] !== 16'd0 || ps[d] !== 2'd0)
                $display("FAIL reset_vals d=%0d got dr=%b st=%b bz=%b dn=%b to=%b cc=%0d ps=%0d exp 1 0 0 0 0 0 0",
                         d, dr[d], st[d], bz[d], dn[d], to[d], cc[d], ps[d]);
            else pass_cnt++;
        end
        Reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk_cnt++;
            if (dr[d] !== 1'b1) $display("FAIL dutreset_hold d=%0d got %b exp 1", d, dr[d]);
            else pass_cnt++;
        end
        @(negedge Clk);
        for (int d = 0; d < 2; d++) begin
            chk_cnt++;
            if (dr[d] !== 1'b0 || bz[d] !== 1'b0) $display("FAIL dutreset_release d=%0d got dr=%b bz=%b exp 0 0", d, dr[d], bz[d]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_first_run;
        do_run(1'b1, 2'd2, 37, 1'b0, 1'b0);
    endtask

    task automatic test_stale_ack;
        do_run(1'b0, 2'd1, 5, 1'b1, 1'b0);
    endtask

    task automatic test_timeout;
        do_run(1'b0, 2'd3, NEVER, 1'b0, 1'b0);
    endtask

    task automatic test_simultaneous;
        do_run(1'b1, 2'd0, 19, 1'b0, 1'b1);
        do_run(1'b0, 2'd2, 8, 1'b0, 1'b1);
    endtask

    task automatic test_mid_reset;
        @(negedge Clk);
        RunReq = 1'b1; RunProg = 2'd1; ResetFirst = 1'b1; Ack = 1'b0;
        @(negedge Clk);
        RunReq = 1'b0;
        repeat (RC + SC + 10) @(negedge Clk);
        for (int d = 0; d < 2; d++) begin
            chk_cnt++;
            if (bz[d] !== 1'b1) $display("FAIL midrun_busy d=%0d got %b exp 1", d, bz[d]);
            else pass_cnt++;
        end
        Reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk_cnt++;
            if (dr[d] !== 1'b1 || st[d] !== 1'b0 || bz[d] !== 1'b0 || dn[d] !== 1'b0 ||
                to[d] !== 1'b0 || cc[d] !== 16'd0 || ps[d] !== 2'd0)
                $display("FAIL midrun_reset d=%0d got dr=%b st=%b bz=%b dn=%b to=%b cc=%0d ps=%0d exp 1 0 0 0 0 0 0",
                         d, dr[d], st[d], bz[d], dn[d], to[d], cc[d], ps[d]);
            else pass_cnt++;
        end
        repeat (2) begin
            @(negedge Clk);
            for (int d = 0; d < 2; d++) begin
                chk_cnt++;
                if (dn[d] !== 1'b0 || dr[d] !== 1'b1) $display("FAIL midrun_nodone d=%0d got dn=%b dr=%b exp 0 1", d, dn[d], dr[d]);
                else pass_cnt++;
            end
        end
        Reset = 1'b0;
        @(negedge Clk);
        for (int d = 0; d < 2; d++) begin
            prev_cc[d] = 0;
            prev_to[d] = 1'b0;
        end
        do_run(1'b0, 2'd3, 13, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 6; n++) begin
            int k;
            k = ($urandom % 4 == 0) ? NEVER : int'($urandom_range(0, 45));
            do_run(1'($urandom), 2'($urandom), k, 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset;
        test_reset_first_run;
        test_stale_ack;
        test_timeout;
        test_simultaneous;
        test_mid_reset;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got running exp finished");
        $fatal(1, "watchdog");
    end

endmodule
